fp32_divider: RTL and testbench



---
 rtl/fp32_pkg.sv | 18 +
 rtl/fp32_div_core.sv | 48 ++++
 rtl/fp32_divider.sv | 116 +++++++++++
 tb/tb_fp32_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32 types, constants and operand classification for the divider
package fp32_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef struct packed {
    logic sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;
  typedef enum logic [2:0] {IDLE, DIV, SPECIAL, NORM, DONE} div_state_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;
  function automatic fp_class_t fp_class(input fp32_t x);
    return x.exp == 8'd0 ? ZERO :
           x.exp != 8'(EXP_MAX) ? NORMAL :
           x.frac != 23'd0 ? NAN : INF;
  endfunction
endpackage

// File: rtl/fp32_div_core.sv
// fp32_div_core: radix-2 restoring significand divider, one quotient bit per step
//   clk, rst_n     clock, async active-low reset
//   load           capture mant_a/mant_b, clear quotient and count
//   step           generate one quotient bit
//   mant_a, mant_b 24-bit significands with hidden one
//   q              quotient bits, MSB first
//   rem_nz         partial remainder non-zero (sticky source)
//   last           current step produces the final quotient bit
module fp32_div_core #(
  parameter int ITER = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [23:0]     mant_a,
  input  logic [23:0]     mant_b,
  output logic [ITER-1:0] q,
  output logic            rem_nz,
  output logic            last
);
  localparam int CW = $clog2(ITER);
  logic [24:0] rem;
  logic [23:0] dv;
  logic [CW-1:0] cnt;
  logic [24:0] diff;
  logic borrow;
  assign {borrow, diff} = {1'b0, rem} - {2'b00, dv};
  assign rem_nz = |rem;
  assign last = cnt == CW'(ITER - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      dv <= '0;
      q <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= {1'b0, mant_a};
      dv <= mant_b;
      q <= '0;
      cnt <= '0;
    end else if (step) begin
      q <= {q[ITER-2:0], ~borrow};
      rem <= borrow ? rem << 1 : diff << 1;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/fp32_divider.sv
// fp32_divider: iterative IEEE-754 single-precision divider res = a / b with valid/ready handshakes
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_ready    operand handshake (in_ready only in IDLE)
//   a, b                  dividend, divisor (fp32, denormals flush to zero)
//   out_valid, out_ready  result handshake, result held until accepted
//   res, div_by_zero      quotient and finite/zero flag, qualified by out_valid
//   FPDIV_ROUND_EN        defined: round-to-nearest-even; undefined: truncation
module fp32_divider
  import fp32_pkg::*;
#(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        div_by_zero
);
  div_state_t state, nxt;
  fp32_t fa, fb;
  fp_class_t ca, cb;
  logic sign, load, last, rem_nz;
  logic signed [9:0] exp_tmp, e_n, e_r;
  logic [ITER-1:0] q;
  logic [22:0] mant, mant_r;
  logic guard, sticky, spec_nan, spec_dbz;
  logic [31:0] norm_res, spec_res;
  assign fa = a;
  assign fb = b;
  assign load = state == IDLE && in_valid;
  fp32_div_core #(.ITER(ITER)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (state == DIV),
    .mant_a({1'b1, fa.frac}),
    .mant_b({1'b1, fb.frac}),
    .q     (q),
    .rem_nz(rem_nz),
    .last  (last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE: nxt = in_valid ? ((fp_class(fa) != NORMAL || fp_class(fb) != NORMAL) ? SPECIAL : DIV) : IDLE;
      DIV: nxt = last ? NORM : DIV;
      SPECIAL, NORM: nxt = DONE;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // q[25] set means a's significand >= b's, so the quotient is already normalised
`ifdef FPDIV_ROUND_EN
  logic carry;
`else
  logic unused_round;
`endif
  always_comb begin
    mant = q[25] ? q[24:2] : q[23:1];
    guard = q[25] ? q[1] : q[0];
    sticky = (q[25] & q[0]) | rem_nz;
    e_n = q[25] ? exp_tmp : exp_tmp - 10'sd1;
`ifdef FPDIV_ROUND_EN
    {carry, mant_r} = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    e_r = carry ? e_n + 10'sd1 : e_n;
`else
    unused_round = guard ^ sticky;
    mant_r = mant;
    e_r = e_n;
`endif
    norm_res = e_r >= 10'sd255 ? {sign, 8'hFF, 23'd0} :
               e_r <= 10'sd0 ? {sign, 31'd0} : {sign, e_r[7:0], mant_r};
  end
  // 0/0, inf/inf and nan/nan all fall out of ca == cb with a non-normal class
  always_comb begin
    spec_nan = ca == NAN || cb == NAN || (ca == cb && ca != NORMAL);
    spec_dbz = ca == NORMAL && cb == ZERO;
    spec_res = spec_nan ? QNAN : (ca == INF || cb == ZERO) ? {sign, 8'hFF, 23'd0} : {sign, 31'd0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      exp_tmp <= '0;
      ca <= ZERO;
      cb <= ZERO;
      res <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        sign <= fa.sign ^ fb.sign;
        exp_tmp <= {2'b00, fa.exp} - {2'b00, fb.exp} + 10'(EXP_BIAS);
        ca <= fp_class(fa);
        cb <= fp_class(fb);
      end
      if (state == NORM) begin
        res <= norm_res;
        div_by_zero <= 1'b0;
      end
      if (state == SPECIAL) begin
        res <= spec_res;
        div_by_zero <= spec_dbz;
      end
    end
  end
endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed and random checks of fp32_divider against an integer-arithmetic reference
module tb_fp32_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [31:0] res;
  int checks = 0;
  int failures = 0;

  fp32_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Exact quotient from integer division, then normalise/round per IEEE rules
  function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic s, g, st;
    int ex, ey, e;
    longint n, d, qq, rr;
    logic [24:0] m;
    bit xn, xi, xz, yn, yi, yz;
`ifndef FPDIV_ROUND_EN
    logic unused_gs;
`endif
    s = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = ex == 0; xi = ex == 255 && x[22:0] == 0; xn = ex == 255 && x[22:0] != 0;
    yz = ey == 0; yi = ey == 255 && y[22:0] == 0; yn = ey == 255 && y[22:0] != 0;
    if (xn || yn || (xz && yz) || (xi && yi)) return {1'b0, 32'h7FC00000};
    if (xi || yz) return {!xi, s, 8'hFF, 23'd0};
    if (yi || xz) return {1'b0, s, 31'd0};
    n = longint'({1'b1, x[22:0]}) << 25;
    d = longint'({1'b1, y[22:0]});
    qq = n / d;
    rr = n % d;
    e = ex - ey + 127;
    if (qq >= (longint'(1) << 25)) begin
      m = 25'(qq >> 2); g = qq[1]; st = qq[0] || rr != 0;
    end else begin
      m = 25'(qq >> 1); g = qq[0]; st = rr != 0; e = e - 1;
    end
`ifdef FPDIV_ROUND_EN
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) e = e + 1;
`else
    unused_gs = g ^ st;
`endif
    if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), m[22:0]};
  endfunction

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
    int lat;
    start_op(ta, tb_v);
    wait_done(lat);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    chk({tag, "_lat"}, lat, exp_lat);
    ack();
  endtask

  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'd0 || x[30:23] == 8'hFF || y[30:23] == 8'd0 || y[30:23] == 8'hFF) ? 2 : 28;
  endfunction

  initial begin
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic [7:0] pick;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
`ifdef FPDIV_ROUND_EN
    run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);
`else
    run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28);
`endif
    run_op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 2);
    run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 28);
    run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 28);
    run_op("inf_by_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 2);
    run_op("inf_by_zero", 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 2);
    run_op("x_by_inf", 32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 2);
    run_op("nan_in", 32'h3F800000, 32'h7F812345, 32'h7FC00000, 1'b0, 2);

    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0, 1: begin
          ra = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
        end
        2: begin
          ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        default: begin
          pick = 8'($urandom_range(0, 2));
          ra = {1'($urandom), pick == 0 ? 8'd0 : pick == 1 ? 8'hFF : 8'($urandom_range(1, 254)),
                ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
          pick = 8'($urandom_range(0, 2));
          rb = {1'($urandom), pick == 0 ? 8'd0 : pick == 1 ? 8'hFF : 8'($urandom_range(1, 254)),
                ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
        end
      endcase
      r = ref_div(ra, rb);
      run_op($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, r[31:0], r[32], ref_lat(ra, rb));
    end

    begin
      int lat;
      start_op(32'h40C00000, 32'h40000000);
      wait_done(lat);
      chk("hold_lat", lat, 28);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = ~in_valid; a = $urandom; b = $urandom;
        @(posedge clk);
        #1;
        chk("hold_res", res, 32'h40400000);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      ack();
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1 chk("idle_stays_idle", {31'd0, in_ready}, 32'd1);
    end

    start_op(32'h40C00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_res", res, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
